draw_field_pipe: RTL and testbench

DRAW_FIELD_PIPE -- requirements
Module: draw_field_pipe

---
 rtl/draw_field_pipe.sv | 192 +++++++++++++++++++
 tb/tb_draw_field_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_field_pipe.sv
// Snake playfield renderer: raster pixel stream in, registered RGB out after two stages.
// Position comes from counters only; the game state is frozen at each frame start.
module draw_field_pipe #(
  parameter int SIZE_X       = 16,
  parameter int SIZE_Y       = 16,
  parameter int SQUARE_SIZE  = 16,
  parameter int H_ACTIVE     = 640,
  parameter int GRID_EN      = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        frame_start_i,
  input  logic                        pix_valid_i,
  input  logic [SIZE_X*SIZE_Y-1:0]    snake_tail_i,
  input  logic [$clog2(SIZE_X)-1:0]   head_x_i,
  input  logic [$clog2(SIZE_Y)-1:0]   head_y_i,
  input  logic [$clog2(SIZE_X)-1:0]   apple_x_i,
  input  logic [$clog2(SIZE_Y)-1:0]   apple_y_i,
  input  logic                        game_over_i,
  output logic [2:0]                  color_o,
  output logic                        color_valid_o
);

  localparam int XW = $clog2(SIZE_X);
  localparam int YW = $clog2(SIZE_Y);
  localparam int CW = $clog2(SIZE_X + 1);
  localparam int RW = $clog2(SIZE_Y + 1);
  localparam int SW = $clog2(SQUARE_SIZE);
  localparam int PW = $clog2(H_ACTIVE);
  localparam int NB = SIZE_X * SIZE_Y;
  localparam int IW = $clog2(NB);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] WHITE  = 3'b111;

  function automatic logic [2:0] pick_color(input logic outside, input logic grid,
                                            input logic head, input logic apple,
                                            input logic body, input logic go,
                                            input logic phase);
    logic [2:0] dead_c;
    dead_c = phase ? WHITE : RED;
    if (outside)    return BLACK;
    else if (grid)  return BLUE;
    else if (head)  return go ? dead_c : YELLOW;
    else if (apple) return RED;
    else if (body)  return go ? dead_c : GREEN;
    else            return WHITE;
  endfunction

  logic [PW-1:0] x_pix;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] sub_x, sub_y;
  logic          synced;
  logic [NB-1:0] snap_tail;
  logic [XW-1:0] snap_hx, snap_ax;
  logic [YW-1:0] snap_hy, snap_ay;
  logic          snap_go, snap_phase;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic          fs, accept;
  logic [PW-1:0] cur_x, nx;
  logic [CW-1:0] cur_col, ncol;
  logic [RW-1:0] cur_row, nrow;
  logic [SW-1:0] cur_sx, cur_sy, nsx, nsy;
  logic [NB-1:0] eff_tail;
  logic [XW-1:0] eff_hx, eff_ax;
  logic [YW-1:0] eff_hy, eff_ay;
  logic          eff_go, eff_phase;
  logic [IW-1:0] bit_idx;

  logic out_p1, grid_p1, head_p1, apple_p1, body_p1, go_p1, phase_p1, vld_p1;
  logic [2:0] color_p2;
  logic       vld_p2;

  assign fs     = pix_valid_i & frame_start_i;
  assign accept = pix_valid_i & (synced | frame_start_i);

  // A frame-start pixel is (0,0) and renders from the incoming state, not the old snapshot.
  assign cur_x     = fs ? '0 : x_pix;
  assign cur_col   = fs ? '0 : col;
  assign cur_row   = fs ? '0 : row;
  assign cur_sx    = fs ? '0 : sub_x;
  assign cur_sy    = fs ? '0 : sub_y;
  assign eff_tail  = fs ? snake_tail_i : snap_tail;
  assign eff_hx    = fs ? head_x_i     : snap_hx;
  assign eff_hy    = fs ? head_y_i     : snap_hy;
  assign eff_ax    = fs ? apple_x_i    : snap_ax;
  assign eff_ay    = fs ? apple_y_i    : snap_ay;
  assign eff_go    = fs ? game_over_i  : snap_go;
  assign eff_phase = fs ? blink_phase  : snap_phase;

  always_comb begin
    nx   = cur_x + PW'(1);
    ncol = cur_col;
    nrow = cur_row;
    nsx  = cur_sx;
    nsy  = cur_sy;
    if (cur_x == PW'(H_ACTIVE - 1)) begin
      nx   = '0;
      nsx  = '0;
      ncol = '0;
      if (cur_sy == SW'(SQUARE_SIZE - 1)) begin
        nsy = '0;
        if (cur_row != RW'(SIZE_Y)) nrow = cur_row + RW'(1);
      end else begin
        nsy = cur_sy + SW'(1);
      end
    end else if (cur_sx == SW'(SQUARE_SIZE - 1)) begin
      nsx = '0;
      if (cur_col != CW'(SIZE_X)) ncol = cur_col + CW'(1);
    end else begin
      nsx = cur_sx + SW'(1);
    end
  end

  assign bit_idx = IW'(int'(cur_col) * SIZE_Y + int'(cur_row));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_pix       <= '0;
      col         <= '0;
      row         <= '0;
      sub_x       <= '0;
      sub_y       <= '0;
      synced      <= 1'b0;
      snap_tail   <= '0;
      snap_hx     <= '0;
      snap_hy     <= '0;
      snap_ax     <= '0;
      snap_ay     <= '0;
      snap_go     <= 1'b0;
      snap_phase  <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      color_p2    <= BLACK;
    end else begin
      if (accept) begin
        x_pix <= nx;
        col   <= ncol;
        row   <= nrow;
        sub_x <= nsx;
        sub_y <= nsy;
      end
      if (fs) begin
        synced     <= 1'b1;
        snap_tail  <= snake_tail_i;
        snap_hx    <= head_x_i;
        snap_hy    <= head_y_i;
        snap_ax    <= apple_x_i;
        snap_ay    <= apple_y_i;
        snap_go    <= game_over_i;
        snap_phase <= blink_phase;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
      vld_p1 <= accept;
      // Stage 2: colour resolve; holds its value on invalid slots.
      vld_p2 <= vld_p1;
      if (vld_p1)
        color_p2 <= pick_color(out_p1, grid_p1, head_p1, apple_p1, body_p1, go_p1, phase_p1);
    end
  end

  // Stage 1: cell lookup flags. Out-of-range head/apple coordinates never equal an inside cell.
  always_ff @(posedge clk_i) begin
    out_p1   <= (cur_col == CW'(SIZE_X)) || (cur_row == RW'(SIZE_Y));
    grid_p1  <= (GRID_EN != 0) && ((cur_sx == '0) || (cur_sy == '0));
    head_p1  <= (cur_col == CW'(eff_hx)) && (cur_row == RW'(eff_hy));
    apple_p1 <= (cur_col == CW'(eff_ax)) && (cur_row == RW'(eff_ay));
    body_p1  <= eff_tail[bit_idx];
    go_p1    <= eff_go;
    phase_p1 <= eff_phase;
  end

  assign color_o       = color_p2;
  assign color_valid_o = vld_p2;

endmodule

// File: tb/tb_draw_field_pipe.sv
// Bench for draw_field_pipe: pixel-coordinate reference model, probe table and corner sequences,
// run against a grid-enabled and a grid-disabled instance driven with identical stimulus.
module tb_draw_field_pipe;

  localparam int SX = 16;
  localparam int SY = 16;
  localparam int SQ = 16;
  localparam int HA = 272;
  localparam int BF = 2;

  localparam logic [2:0] BLK = 3'b000;
  localparam logic [2:0] BLU = 3'b001;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b110;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] WHT = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fs_i = 1'b0;
  logic         pv_i = 1'b0;
  logic [255:0] tail = '0;
  logic [3:0]   hx = '0, hy = '0, ax = '0, ay = '0;
  logic         go = 1'b0;
  logic [2:0]   col_g, col_n;
  logic         vld_g, vld_n;

  always #5 clk = ~clk;

  draw_field_pipe #(.SIZE_X(SX), .SIZE_Y(SY), .SQUARE_SIZE(SQ), .H_ACTIVE(HA),
                    .GRID_EN(1), .BLINK_FRAMES(BF)) dut_g (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs_i), .pix_valid_i(pv_i),
    .snake_tail_i(tail), .head_x_i(hx), .head_y_i(hy), .apple_x_i(ax), .apple_y_i(ay),
    .game_over_i(go), .color_o(col_g), .color_valid_o(vld_g));

  draw_field_pipe #(.SIZE_X(SX), .SIZE_Y(SY), .SQUARE_SIZE(SQ), .H_ACTIVE(HA),
                    .GRID_EN(0), .BLINK_FRAMES(BF)) dut_n (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs_i), .pix_valid_i(pv_i),
    .snake_tail_i(tail), .head_x_i(hx), .head_y_i(hy), .apple_x_i(ax), .apple_y_i(ay),
    .game_over_i(go), .color_o(col_n), .color_valid_o(vld_n));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pixel coordinates as plain integers plus the frozen frame state.
  bit           m_synced = 1'b0;
  int           m_px = 0, m_py = 0, m_nfr = 0;
  logic [255:0] s_tail = '0;
  int           s_hx = 0, s_hy = 0, s_ax = 0, s_ay = 0;
  bit           s_go = 1'b0, s_ph = 1'b0;
  bit           p_v[2];
  logic [2:0]   p_cg[2], p_cn[2];
  logic [2:0]   h_g = BLK, h_n = BLK;

  typedef struct {
    bit         restart;
    int         ax, ay, hx, hy, tb0, tb1;
    int         px, py;
    logic [2:0] eg, en;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit r, int a_x, int a_y, int h_x, int h_y, int b0, int b1,
                              int px, int py, logic [2:0] eg, logic [2:0] en);
    vec_t v;
    v.restart = r; v.ax = a_x; v.ay = a_y; v.hx = h_x; v.hy = h_y;
    v.tb0 = b0; v.tb1 = b1; v.px = px; v.py = py; v.eg = eg; v.en = en;
    return v;
  endfunction

  function automatic logic [2:0] mcolor(bit g, int px, int py);
    int cx, cy;
    cx = px / SQ;
    cy = py / SQ;
    if (cx >= SX || cy >= SY) return BLK;
    if (g && ((px % SQ) == 0 || (py % SQ) == 0)) return BLU;
    if (cx == s_hx && cy == s_hy) return s_go ? (s_ph ? WHT : RED) : YEL;
    if (cx == s_ax && cy == s_ay) return RED;
    if (s_tail[cx * SY + cy]) return s_go ? (s_ph ? WHT : RED) : GRN;
    return WHT;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit fs, input bit pv, input bit r);
    bit nv;
    logic [2:0] ncg, ncn;
    fs_i = fs; pv_i = pv; rst = r;
    nv = 1'b0; ncg = BLK; ncn = BLK;
    if (!r && pv && (fs || m_synced)) begin
      if (fs) begin
        m_synced = 1'b1;
        m_px = 0; m_py = 0;
        s_tail = tail; s_hx = int'(hx); s_hy = int'(hy); s_ax = int'(ax); s_ay = int'(ay);
        s_go = go;
        s_ph = ((m_nfr / BF) % 2) == 1;
        m_nfr++;
      end
      nv  = 1'b1;
      ncg = mcolor(1'b1, m_px, m_py);
      ncn = mcolor(1'b0, m_px, m_py);
      m_px++;
      if (m_px == HA) begin m_px = 0; m_py++; end
    end
    @(posedge clk);
    #1;
    if (r) begin
      p_v[0] = 1'b0; p_v[1] = 1'b0;
      h_g = BLK; h_n = BLK;
      m_synced = 1'b0; m_nfr = 0; m_px = 0; m_py = 0;
      s_tail = '0; s_hx = 0; s_hy = 0; s_ax = 0; s_ay = 0; s_go = 1'b0; s_ph = 1'b0;
    end else begin
      p_v[1] = p_v[0]; p_cg[1] = p_cg[0]; p_cn[1] = p_cn[0];
      p_v[0] = nv;     p_cg[0] = ncg;     p_cn[0] = ncn;
      if (p_v[1]) begin h_g = p_cg[1]; h_n = p_cn[1]; end
    end
    chk("valid_g", 32'(vld_g), 32'(p_v[1]));
    chk("valid_n", 32'(vld_n), 32'(p_v[1]));
    chk("color_g", 32'(col_g), 32'(h_g));
    chk("color_n", 32'(col_n), 32'(h_n));
  endtask

  // Stream pixels until (px,py) is accepted, idle two cycles, then compare the held colour.
  task automatic probe(input string nm, input int px, input int py,
                       input logic [2:0] eg, input logic [2:0] en);
    int n;
    n = 0;
    while ((m_px != px || m_py != py) && n < 40000) begin
      tick(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk({nm, "_reach"}, 32'(n < 40000), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk({nm, "_grid"}, 32'(col_g), 32'(eg));
    chk({nm, "_nogrid"}, 32'(col_n), 32'(en));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_go[6];
    exp_go = '{RED, RED, WHT, WHT, RED, RED};

    tbl[0]  = mk(1, 3, 2, 15, 15, -1, -1,  16,   5, BLU, WHT);
    tbl[1]  = mk(0, 3, 2, 15, 15, -1, -1,  48,  32, BLU, RED);
    tbl[2]  = mk(0, 3, 2, 15, 15, -1, -1,  49,  33, RED, RED);
    tbl[3]  = mk(0, 3, 2, 15, 15, -1, -1,  50,  50, WHT, WHT);
    tbl[4]  = mk(1, 5, 7,  5,  7, 87,  0,   5,   5, GRN, GRN);
    tbl[5]  = mk(0, 5, 7,  5,  7, 87,  0,  80, 112, BLU, YEL);
    tbl[6]  = mk(0, 5, 7,  5,  7, 87,  0,  81, 113, YEL, YEL);
    tbl[7]  = mk(1, 3, 0, 15, 15, -1, -1,  49,   1, RED, RED);
    tbl[8]  = mk(0, 6, 0, 15, 15, -1, -1,  97,   2, WHT, WHT);
    tbl[9]  = mk(0, 6, 0, 15, 15, -1, -1,  49,   3, RED, RED);
    tbl[10] = mk(1, 6, 0, 15, 15, -1, -1,  97,   1, RED, RED);
    tbl[11] = mk(0, 6, 0, 15, 15, -1, -1, 255,   1, WHT, WHT);
    tbl[12] = mk(0, 6, 0, 15, 15, -1, -1, 256,   1, BLK, BLK);
    tbl[13] = mk(0, 6, 0, 15, 15, -1, -1,  49,   2, WHT, WHT);

    // Reset state, then pixels before any frame start must be dropped.
    tick(1'b0, 1'b0, 1'b1);
    chk("rst_color", 32'(col_g), 32'(BLK));
    chk("rst_valid", 32'(vld_g), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);

    // Probe table.
    for (int i = 0; i < 14; i++) begin
      ax = 4'(tbl[i].ax); ay = 4'(tbl[i].ay);
      hx = 4'(tbl[i].hx); hy = 4'(tbl[i].hy);
      go = 1'b0;
      tail = '0;
      if (tbl[i].tb0 >= 0) tail[tbl[i].tb0] = 1'b1;
      if (tbl[i].tb1 >= 0) tail[tbl[i].tb1] = 1'b1;
      if (tbl[i].restart) tick(1'b1, 1'b1, 1'b0);
      probe($sformatf("vec%0d", i), tbl[i].px, tbl[i].py, tbl[i].eg, tbl[i].en);
    end

    // Resync mid-line: the frame-start pixel becomes (0,0).
    tail = '0; hx = 4'd15; hy = 4'd15; ax = 4'd3; ay = 4'd2; go = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 400 && m_px != 100; n++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("resync_grid", 32'(col_g), 32'(BLU));
    chk("resync_nogrid", 32'(col_n), 32'(WHT));
    probe("past_field", 260, 0, BLK, BLK);

    // One line with pixels gapped 1-in-3.
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3 * HA; i++) tick(1'b0, (i % 3) == 0, 1'b0);

    // Game-over blink across six frames after a fresh reset.
    tick(1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 6; f++) begin
      tail = '0; tail[16] = 1'b1;
      hx = 4'd2; hy = 4'd0; ax = 4'd3; ay = 4'd0; go = 1'b1;
      tick(1'b1, 1'b1, 1'b0);
      probe($sformatf("go_body_f%0d", f), 20, 3, exp_go[f], exp_go[f]);
      probe($sformatf("go_head_f%0d", f), 36, 3, exp_go[f], exp_go[f]);
      probe($sformatf("go_apple_f%0d", f), 52, 3, RED, RED);
      go = 1'b0;
      probe($sformatf("go_frozen_f%0d", f), 20, 5, exp_go[f], exp_go[f]);
    end

    // Randomized traffic against the model, including a reset colliding with frame start.
    for (int i = 0; i < 3000; i++) begin
      bit r, f, p;
      if ($urandom_range(19) == 0) begin
        for (int k = 0; k < 8; k++) tail[k*32 +: 32] = $urandom;
        hx = 4'($urandom_range(15)); hy = 4'($urandom_range(15));
        ax = 4'($urandom_range(15)); ay = 4'($urandom_range(15));
        go = 1'($urandom_range(1));
      end
      r = (i == 1500) || ($urandom_range(999) == 0);
      f = (i == 1500) || (i == 2) || ($urandom_range(299) == 0);
      p = $urandom_range(3) != 0;
      tick(f, p, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
